// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls words from an upstream synchronous FIFO and sends each
// one as an asynchronous serial frame on tx (start bit, data LSB first, stop bit).
// Every output is a flop; the next-value logic is computed from the next state,
// so the outputs stay aligned with the state register.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_read,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(WIDTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              fifo_read_q, fifo_read_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              baud_wrap;

    assign fifo_read = fifo_read_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;

    assign baud_wrap = (baud_q == BAUD_LAST);

    // Next-state, counter and shift-register logic, then outputs derived from the next state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // FIFO read data is valid in this cycle, one after the strobe.
                shift_d = fifo_data;
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                baud_d = baud_wrap ? '0 : baud_q + 1'b1;
                if (baud_wrap) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = baud_wrap ? '0 : baud_q + 1'b1;
                if (baud_wrap) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                baud_d = baud_wrap ? '0 : baud_q + 1'b1;
                if (baud_wrap) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        tx_d = 1'b1;
        if (state_d == S_START) begin
            tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            tx_d = shift_d[0];
        end
        fifo_read_d = (state_d == S_FETCH);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    end

    // State, counters, shift register and registered outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            fifo_read_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            fifo_read_q <= fifo_read_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench. Stimulus loads bytes into behavioural FIFOs
// and pushes the expected bytes into queues; independent monitors decode frames
// from tx and compare against the queues.
module tb_fifo_uart_tx;

    localparam int W      = 8;
    localparam int CPB    = 4;
    localparam int FRAME  = CPB * (W + 2);
    localparam int W5     = 5;
    localparam int CPB5   = 2;
    localparam int FRAME5 = CPB5 * (W5 + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_data = '0;
    logic          fifo_read, tx, busy, done;
    logic          fifo_empty5 = 1'b1;
    logic [W5-1:0] fifo_data5 = '0;
    logic          fifo_read5, tx5, busy5, done5;

    int checks = 0;
    int failures = 0;

    logic [W-1:0]  fifo_q[$];
    logic [W-1:0]  exp_q[$];
    logic [W5-1:0] fifo5_q[$];
    logic [W5-1:0] exp5_q[$];

    int rd_cnt = 0, rd5_cnt = 0;
    int done_cnt = 0, done5_cnt = 0;

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    fifo_uart_tx #(.WIDTH(W5), .CLKS_PER_BIT(CPB5)) u_dut5 (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty5),
        .fifo_data  (fifo_data5),
        .fifo_read  (fifo_read5),
        .tx         (tx5),
        .busy       (busy5),
        .done       (done5)
    );

    // Behavioural FIFOs: registered read data, registered empty flag.
    always @(posedge clk) begin
        int n;
        n = fifo_q.size();
        if (fifo_read) begin
            rd_cnt++;
            if (n == 0) begin
                checks++; failures++;
                $display("FAIL underflow: fifo_read=1 got with empty FIFO, required no read");
            end else begin
                fifo_data <= fifo_q.pop_front();
                n--;
            end
        end
        fifo_empty <= (n == 0);
    end

    always @(posedge clk) begin
        int n;
        n = fifo5_q.size();
        if (fifo_read5) begin
            rd5_cnt++;
            if (n == 0) begin
                checks++; failures++;
                $display("FAIL underflow5: fifo_read=1 got with empty FIFO, required no read");
            end else begin
                fifo_data5 <= fifo5_q.pop_front();
                n--;
            end
        end
        fifo_empty5 <= (n == 0);
    end

    // Monitor for the WIDTH=8 instance.
    int fcnt = 0, gap = 0, last_gap = -1;
    logic fr [0:FRAME-1];
    logic fb [0:FRAME-1];
    logic [W-1:0] got_m, exp_m;
    bit shape_ok, busy_ok;

    always @(negedge clk) begin
        if (!reset) begin
            fcnt = 0;
            gap  = 0;
        end else begin
            if (done) done_cnt++;
            if (fcnt == 0) begin
                if (done) begin
                    checks++; failures++;
                    $display("FAIL done_stray: done=1 got outside frame end, required 0");
                end
                if (!tx) begin
                    fr[0] = tx; fb[0] = busy; fcnt = 1;
                    last_gap = gap; gap = 0;
                end else begin
                    gap++;
                end
            end else begin
                fr[fcnt] = tx; fb[fcnt] = busy; fcnt++;
                if (fcnt == FRAME) begin
                    checks++;
                    if (!done) begin
                        failures++;
                        $display("FAIL done_end: done=0 got on frame cycle %0d, required 1", FRAME);
                    end
                    shape_ok = 1; busy_ok = 1;
                    for (int b = 0; b < W + 2; b++)
                        for (int k = 0; k < CPB; k++)
                            if (fr[b*CPB+k] !== fr[b*CPB]) shape_ok = 0;
                    for (int c = 0; c < FRAME; c++)
                        if (fb[c] !== 1'b1) busy_ok = 0;
                    for (int i = 0; i < W; i++) got_m[i] = fr[(i+1)*CPB];
                    checks++;
                    if (!shape_ok || fr[0] !== 1'b0 || fr[(W+1)*CPB] !== 1'b1) begin
                        failures++;
                        $display("FAIL frame_shape: start=%b stop=%b uniform=%0d, required start=0 stop=1 uniform=1",
                                 fr[0], fr[(W+1)*CPB], shape_ok);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL frame_unexpected: got byte 0x%02h, required no frame", got_m);
                    end else begin
                        exp_m = exp_q.pop_front();
                        if (got_m !== exp_m) begin
                            failures++;
                            $display("FAIL frame_data: got 0x%02h, required 0x%02h", got_m, exp_m);
                        end
                    end
                    checks++;
                    if (!busy_ok) begin
                        failures++;
                        $display("FAIL busy_frame: busy=0 got inside frame, required 1");
                    end
                    $display("frame8 byte=0x%02h gap_before=%0d", got_m, last_gap);
                    fcnt = 0;
                end else if (done) begin
                    checks++; failures++;
                    $display("FAIL done_stray: done=1 got on frame cycle %0d, required 0", fcnt);
                end
            end
        end
    end

    // Monitor for the WIDTH=5, CLKS_PER_BIT=2 instance.
    int fcnt5 = 0;
    logic fr5 [0:FRAME5-1];
    logic [W5-1:0] got5_m, exp5_m;
    bit shape5_ok;

    always @(negedge clk) begin
        if (!reset) begin
            fcnt5 = 0;
        end else begin
            if (done5) done5_cnt++;
            if (fcnt5 == 0) begin
                if (done5) begin
                    checks++; failures++;
                    $display("FAIL done5_stray: done=1 got outside frame end, required 0");
                end
                if (!tx5) begin
                    fr5[0] = tx5; fcnt5 = 1;
                end
            end else begin
                fr5[fcnt5] = tx5; fcnt5++;
                if (fcnt5 == FRAME5) begin
                    checks++;
                    if (!done5) begin
                        failures++;
                        $display("FAIL done5_end: done=0 got on frame cycle %0d, required 1", FRAME5);
                    end
                    shape5_ok = 1;
                    for (int b = 0; b < W5 + 2; b++)
                        for (int k = 0; k < CPB5; k++)
                            if (fr5[b*CPB5+k] !== fr5[b*CPB5]) shape5_ok = 0;
                    for (int i = 0; i < W5; i++) got5_m[i] = fr5[(i+1)*CPB5];
                    checks++;
                    if (!shape5_ok || fr5[0] !== 1'b0 || fr5[(W5+1)*CPB5] !== 1'b1) begin
                        failures++;
                        $display("FAIL frame5_shape: start=%b stop=%b uniform=%0d, required start=0 stop=1 uniform=1",
                                 fr5[0], fr5[(W5+1)*CPB5], shape5_ok);
                    end
                    checks++;
                    if (exp5_q.size() == 0) begin
                        failures++;
                        $display("FAIL frame5_unexpected: got 0x%02h, required no frame", got5_m);
                    end else begin
                        exp5_m = exp5_q.pop_front();
                        if (got5_m !== exp5_m) begin
                            failures++;
                            $display("FAIL frame5_data: got 0x%02h, required 0x%02h", got5_m, exp5_m);
                        end
                    end
                    $display("frame5 byte=0x%02h", got5_m);
                    fcnt5 = 0;
                end else if (done5) begin
                    checks++; failures++;
                    $display("FAIL done5_stray: done=1 got on frame cycle %0d, required 0", fcnt5);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit sel, input int target, input int limit, input string name);
        int t;
        t = 0;
        while (((sel ? done5_cnt : done_cnt) < target) && t < limit) begin
            tick();
            t++;
        end
        checks++;
        if ((sel ? done5_cnt : done_cnt) < target) begin
            failures++;
            $display("FAIL %s: timeout, done count %0d got, required %0d", name,
                     sel ? done5_cnt : done_cnt, target);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    initial begin
        bit idle_ok;
        int t;
        int rd_before;

        // Reset held with a non-empty FIFO: outputs stay at reset values.
        reset = 1'b0;
        fifo_q.push_back(8'hA5);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({tx, fifo_read, busy, done} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_outputs: {tx,rd,busy,done}=%b got, required 1000",
                         {tx, fifo_read, busy, done});
            end
        end

        // Single byte 0xA5.
        reset = 1'b1;
        wait_done(1'b0, 1, 200, "single_done");
        repeat (3) tick();
        check_int("single_reads", rd_cnt, 1);
        check_int("single_dones", done_cnt, 1);

        // Back-to-back 0x00, 0xFF with exactly 3 idle-high cycles between frames.
        fifo_q.push_back(8'h00); exp_q.push_back(8'h00);
        fifo_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        wait_done(1'b0, 3, 300, "b2b_done");
        repeat (3) tick();
        check_int("b2b_gap", last_gap, 3);
        check_int("b2b_reads", rd_cnt, 3);
        check_int("b2b_dones", done_cnt, 3);

        // Empty FIFO for 100 cycles: stays idle.
        idle_ok = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) idle_ok = 0;
        end
        checks++;
        if (!idle_ok) begin
            failures++;
            $display("FAIL empty_idle: activity got with empty FIFO, required tx=1 busy=0 no read");
        end
        check_int("empty_reads", rd_cnt, 3);

        // Reset during DATA bit 3 of 0x3C; the byte is lost.
        rd_before = rd_cnt;
        fifo_q.push_back(8'h3C);
        t = 0;
        while (fcnt != 18 && t < 200) begin
            tick();
            t++;
        end
        check_int("abort_reached_bit3", fcnt, 18);
        reset = 1'b0;
        tick();
        checks++;
        if ({tx, fifo_read, busy, done} !== 4'b1000) begin
            failures++;
            $display("FAIL abort_outputs: {tx,rd,busy,done}=%b got, required 1000",
                     {tx, fifo_read, busy, done});
        end
        reset = 1'b1;
        check_int("abort_no_done", done_cnt, 3);
        fifo_q.push_back(8'h81); exp_q.push_back(8'h81);
        wait_done(1'b0, 4, 300, "after_abort_done");
        repeat (3) tick();
        check_int("after_abort_reads", rd_cnt, rd_before + 2);
        check_int("after_abort_dones", done_cnt, 4);

        // Narrow instance: WIDTH=5, CLKS_PER_BIT=2, byte 0x15.
        fifo5_q.push_back(5'h15); exp5_q.push_back(5'h15);
        wait_done(1'b1, 1, 100, "w5_done");
        repeat (3) tick();
        check_int("w5_reads", rd5_cnt, 1);
        check_int("w5_dones", done5_cnt, 1);

        check_int("exp_queue_drained", exp_q.size(), 0);
        check_int("exp5_queue_drained", exp5_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
